// File: rtl/dsi_pkg.sv
// Shared DSI receive definitions: parser states, header layout, data types,
// CRC-16 byte step and the header ECC column table.
package dsi_pkg;

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CRC, DRAIN} state_t;

  typedef struct packed {
    logic [15:0] wc;
    logic [7:0]  di;
  } hdr_t;

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REV = 16'h8408;

  localparam logic [5:0] DT_ACK_ERR         = 6'h02;
  localparam logic [5:0] DT_EOTP            = 6'h08;
  localparam logic [5:0] DT_GEN_LONG_RESP   = 6'h1A;
  localparam logic [5:0] DT_DCS_LONG_RESP   = 6'h1C;
  localparam logic [5:0] DT_GEN_SHORT_RESP1 = 6'h11;
  localparam logic [5:0] DT_GEN_SHORT_RESP2 = 6'h12;
  localparam logic [5:0] DT_DCS_SHORT_RESP1 = 6'h21;
  localparam logic [5:0] DT_DCS_SHORT_RESP2 = 6'h22;

  // Only the low nibble of DT decides packet length.
  function automatic logic is_long_dt(input logic [3:0] dt);
    return (dt >= 4'h9) && (dt <= 4'hE);
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]} ^ (fb ? CRC_POLY_REV : 16'h0000);
    end
    return c;
  endfunction

  // Parity bits {P5..P0} each header data bit contributes to.
  function automatic logic [5:0] ecc_col(input int i);
    case (i)
      0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
      4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
      8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
     12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
     16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
     20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [3:0] strb_of(input logic [3:0] n);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (4'(i) < n);
    return s;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/ecc_decoder.sv
// Hamming(24,6) header check: corrects any single-bit error (data or parity),
// flags everything else with a non-zero syndrome as fatal.
module ecc_decoder
  import dsi_pkg::*;
(
  input  logic [23:0] hdr,
  input  logic [7:0]  ecc,
  output logic [23:0] hdr_fixed,
  output logic        corrected,
  output logic        fatal
);

  logic [7:0] calc, syn;
  logic       hit;

  always_comb begin
    calc = '0;
    for (int i = 0; i < 24; i++)
      if (hdr[i]) calc = calc ^ {2'b00, ecc_col(i)};
    syn       = calc ^ ecc;
    hdr_fixed = hdr;
    hit       = $onehot(syn);
    for (int i = 0; i < 24; i++)
      if (syn == {2'b00, ecc_col(i)}) begin
        hdr_fixed[i] = ~hdr[i];
        hit          = 1'b1;
      end
    corrected = (syn != 8'h00) && hit;
    fatal     = (syn != 8'h00) && !hit;
  end

endmodule

// File: rtl/packets_parser.sv
// DSI RX packet parser: splits RX bursts into short/long packets through an
// 8-byte staging buffer, fixes headers, realigns payload and checks CRC-16.
module packets_parser
  import dsi_pkg::*;
#(
  parameter bit          CRC_CHECK_EN = 1'b1,
  parameter logic [15:0] WC_MAX       = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic [2:0]  in_nbytes,
  input  logic        in_eot,
  output logic        in_ready,
  output logic        hdr_valid,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic        hdr_ecc_corrected,
  output logic        hdr_ecc_fatal,
  output logic [31:0] pld_data,
  output logic [3:0]  pld_strb,
  output logic        pld_valid,
  output logic        pld_last,
  output logic        pkt_done,
  output logic        crc_err,
  output logic        trunc_err
);

  state_t      state_q, state_n;
  logic [63:0] stg_q, stg_n, stg_sh;
  logic [31:0] in_masked;
  logic [3:0]  fill_q, fill_n, fill_c, ncons, k, nb;
  logic [15:0] rem_q, rem_n, crc_q, crc_n, crc_pl;
  logic        hold_q, hold_n, clear, accept;
  logic        hdr_go, pld_go, last_n, done_go, crc_err_n, trunc_n;
  hdr_t        hdr_fix;
  logic        ecc_corr, ecc_fatal, long_pkt, fatal;

  // hold_q marks "end of burst already accepted"; it resets high so in_ready
  // stays low until the first post-reset cycle lands in IDLE.
  assign in_ready = !hold_q && (fill_q <= 4'd4);
  assign accept   = in_valid && in_ready;

  ecc_decoder u_ecc (
    .hdr       (stg_q[23:0]),
    .ecc       (stg_q[31:24]),
    .hdr_fixed (hdr_fix),
    .corrected (ecc_corr),
    .fatal     (ecc_fatal)
  );

  assign long_pkt = is_long_dt(hdr_fix.di[3:0]);
  assign fatal    = ecc_fatal || (long_pkt && ({1'b0, hdr_fix.wc} > {1'b0, WC_MAX}));
  assign k        = (rem_q >= 16'd4) ? 4'd4 : rem_q[3:0];

  always_comb begin
    crc_pl = crc_q;
    for (int i = 0; i < 4; i++)
      if (4'(i) < k) crc_pl = crc16_byte(crc_pl, stg_q[8*i +: 8]);
    in_masked = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < in_nbytes) in_masked[8*i +: 8] = in_data[8*i +: 8];
  end

  always_comb begin
    state_n = state_q;  hold_n = hold_q;  rem_n = rem_q;  crc_n = crc_q;
    ncons = '0;  clear = 1'b0;  nb = k;
    hdr_go = 1'b0;  pld_go = 1'b0;  last_n = 1'b0;
    done_go = 1'b0;  crc_err_n = 1'b0;  trunc_n = 1'b0;
    if (accept && in_eot) hold_n = 1'b1;
    unique case (state_q)
      IDLE: begin
        hold_n = accept && in_eot;
        if (accept) state_n = HEADER;
      end
      HEADER:
        if (fill_q >= 4'd4) begin
          ncons  = 4'd4;
          hdr_go = 1'b1;
          if (fatal) state_n = DRAIN;
          else if (long_pkt) begin
            crc_n   = CRC_INIT;
            rem_n   = hdr_fix.wc;
            state_n = (hdr_fix.wc != 16'd0) ? PAYLOAD : CRC;
          end else done_go = 1'b1;
        end else if (hold_q) begin
          ncons = fill_q;   // EoT padding
          clear = 1'b1;
        end
      PAYLOAD:
        if (fill_q >= k) begin
          ncons  = k;
          pld_go = 1'b1;
          crc_n  = crc_pl;
          rem_n  = rem_q - {12'd0, k};
          if (rem_q == {12'd0, k}) begin
            last_n  = 1'b1;
            state_n = CRC;
          end
        end else if (hold_q) begin
          ncons   = fill_q;
          nb      = fill_q;
          pld_go  = (fill_q != 4'd0);
          last_n  = 1'b1;
          done_go = 1'b1;
          trunc_n = 1'b1;
          clear   = 1'b1;
        end
      CRC:
        if (fill_q >= 4'd2) begin
          ncons     = 4'd2;
          done_go   = 1'b1;
          crc_err_n = CRC_CHECK_EN && (stg_q[15:0] != crc_q);
          state_n   = HEADER;
        end else if (hold_q) begin
          ncons   = fill_q;
          done_go = 1'b1;
          trunc_n = 1'b1;
          clear   = 1'b1;
        end
      DRAIN: begin
        ncons = fill_q;
        if (hold_q) begin
          done_go = 1'b1;
          clear   = 1'b1;
        end
      end
      default: clear = 1'b1;
    endcase
    if (clear) begin
      state_n = IDLE;
      hold_n  = 1'b0;
    end
    // Consume from byte0 first, then append the new word at the post-consume fill.
    stg_sh = stg_q >> {ncons, 3'b000};
    fill_c = fill_q - ncons;
    stg_n  = stg_sh;
    fill_n = fill_c;
    if (accept) begin
      stg_n  = stg_sh | ({32'd0, in_masked} << {fill_c, 3'b000});
      fill_n = fill_c + {1'b0, in_nbytes};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  hold_q <= 1'b1;  stg_q <= '0;  fill_q <= '0;
      rem_q <= '0;  crc_q <= '0;
      hdr_valid <= 1'b0;  hdr_di <= '0;  hdr_wc <= '0;  hdr_long <= 1'b0;
      hdr_ecc_corrected <= 1'b0;  hdr_ecc_fatal <= 1'b0;
      pld_data <= '0;  pld_strb <= '0;  pld_valid <= 1'b0;  pld_last <= 1'b0;
      pkt_done <= 1'b0;  crc_err <= 1'b0;  trunc_err <= 1'b0;
    end else begin
      state_q <= state_n;  hold_q <= hold_n;  stg_q <= stg_n;  fill_q <= fill_n;
      rem_q <= rem_n;  crc_q <= crc_n;
      hdr_valid <= hdr_go;
      if (hdr_go) begin
        hdr_di            <= hdr_fix.di;
        hdr_wc            <= hdr_fix.wc;
        hdr_long          <= long_pkt;
        hdr_ecc_corrected <= ecc_corr;
        hdr_ecc_fatal     <= fatal;
      end
      pld_valid <= pld_go;
      pld_last  <= pld_go && last_n;
      if (pld_go) begin
        pld_data <= stg_q[31:0] & byte_mask(strb_of(nb));
        pld_strb <= strb_of(nb);
      end
      pkt_done  <= done_go;
      crc_err   <= crc_err_n;
      trunc_err <= trunc_n;
    end
  end

endmodule

// File: tb/tb_packets_parser.sv
// Directed bench for packets_parser: header ECC, payload realignment, CRC,
// fatal drain, truncation and asynchronous reset.
module tb_packets_parser;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_eot = 1'b0;
  logic [2:0]  in_nbytes = 3'd4;
  logic        in_ready, hdr_valid, hdr_long, hdr_ecc_corrected, hdr_ecc_fatal;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [31:0] pld_data;
  logic [3:0]  pld_strb;
  logic        pld_valid, pld_last, pkt_done, crc_err, trunc_err;

  int checks = 0, failures = 0;
  logic [26:0] hq[$];   // {di, wc, long, corrected, fatal}
  logic [36:0] pq[$];   // {last, strb, data}
  logic [1:0]  dq[$];   // {crc_err, trunc_err}

  packets_parser dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_nbytes(in_nbytes), .in_eot(in_eot), .in_ready(in_ready),
    .hdr_valid(hdr_valid), .hdr_di(hdr_di), .hdr_wc(hdr_wc), .hdr_long(hdr_long),
    .hdr_ecc_corrected(hdr_ecc_corrected), .hdr_ecc_fatal(hdr_ecc_fatal),
    .pld_data(pld_data), .pld_strb(pld_strb), .pld_valid(pld_valid),
    .pld_last(pld_last), .pkt_done(pkt_done), .crc_err(crc_err), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    if (hdr_valid) hq.push_back({hdr_di, hdr_wc, hdr_long, hdr_ecc_corrected, hdr_ecc_fatal});
    if (pld_valid) pq.push_back({pld_last, pld_strb, pld_data});
    if (pkt_done)  dq.push_back({crc_err, trunc_err});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  function automatic logic [31:0] hw(input logic [7:0] di, input logic [15:0] wc);
    return {ecc_of({wc, di}), wc, di};
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic e);
    int t;
    in_data = d;  in_nbytes = n;  in_eot = e;  in_valid = 1'b1;  t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;  in_eot = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    hq.delete();  pq.delete();  dq.delete();
  endtask

  task automatic counts(input string tag, input int nh, input int np, input int nd);
    chk({tag, "_hdr_cnt"}, 64'(hq.size()), 64'(nh));
    chk({tag, "_pld_cnt"}, 64'(pq.size()), 64'(np));
    chk({tag, "_done_cnt"}, 64'(dq.size()), 64'(nd));
  endtask

  task automatic exp_hdr(input string tag, input int i, input logic [26:0] e);
    if (hq.size() > i) chk({tag, "_hdr"}, 64'(hq[i]), 64'(e));
  endtask
  task automatic exp_pld(input string tag, input int i, input logic [36:0] e);
    if (pq.size() > i) chk({tag, "_pld"}, 64'(pq[i]), 64'(e));
  endtask
  task automatic exp_done(input string tag, input int i, input logic [1:0] e);
    if (dq.size() > i) chk({tag, "_done"}, 64'(dq[i]), 64'(e));
  endtask

  task automatic short_21();
    clr();
    send(hw(8'h21, 16'h005A), 3'd4, 1'b1);
    idle(10);
    counts("t1", 1, 0, 1);
    exp_hdr("t1", 0, {8'h21, 16'h005A, 3'b000});
    exp_done("t1", 0, 2'b00);
    chk("t1_idle_ready", {63'd0, in_ready}, 64'd1);
  endtask

  logic [15:0] c5;

  initial begin
    idle(2);
    chk("rst_outputs", 64'({in_ready, hdr_valid, hdr_di, hdr_wc, hdr_long, hdr_ecc_corrected,
        hdr_ecc_fatal, pld_strb, pld_valid, pld_last, pkt_done, crc_err, trunc_err}), 64'd0);
    chk("rst_pld_data", 64'(pld_data), 64'd0);
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

    // 1: short read response, single-word burst
    short_21();

    // 2: long WC=5 followed by a short packet at byte offset 11
    c5 = 16'hFFFF;
    for (int b = 1; b <= 5; b++) c5 = crc_upd(c5, 8'(b));
    clr();
    send(hw(8'h1A, 16'h0005), 3'd4, 1'b0);
    send(32'h04030201, 3'd4, 1'b0);
    send({8'h02, c5, 8'h05}, 3'd4, 1'b0);
    send({8'h00, ecc_of(24'h123402), 16'h1234}, 3'd3, 1'b1);
    idle(12);
    counts("t2", 2, 2, 2);
    exp_hdr("t2a", 0, {8'h1A, 16'h0005, 3'b100});
    exp_pld("t2w0", 0, {1'b0, 4'hF, 32'h04030201});
    exp_pld("t2w1", 1, {1'b1, 4'h1, 32'h00000005});
    exp_done("t2a", 0, 2'b00);
    exp_hdr("t2b", 1, {8'h02, 16'h1234, 3'b000});
    exp_done("t2b", 1, 2'b00);

    // 3: single-bit header error (bit 10) corrected
    clr();
    send(hw(8'h21, 16'h005A) ^ 32'h0000_0400, 3'd4, 1'b1);
    idle(10);
    counts("t3", 1, 0, 1);
    exp_hdr("t3", 0, {8'h21, 16'h005A, 3'b010});

    // 4: double-bit header error drains the burst, next burst is clean
    clr();
    send(hw(8'h1A, 16'h0010) ^ 32'h0000_0003, 3'd4, 1'b0);
    for (int w = 0; w < 4; w++) send(32'hA5A5_0000 + 32'(w), 3'd4, 1'b0);
    idle(8);
    chk("t4_no_done_before_eot", 64'(dq.size()), 64'd0);
    send(32'h5A5A_5A5A, 3'd4, 1'b1);
    idle(10);
    counts("t4", 1, 0, 1);
    if (hq.size() > 0) chk("t4_fatal", {63'd0, hq[0][0]}, 64'd1);
    short_21();

    // 5a: corrupted payload byte -> crc_err
    clr();
    send(hw(8'h1A, 16'h0005), 3'd4, 1'b0);
    send(32'h04130201, 3'd4, 1'b0);
    send({8'h02, c5, 8'h05}, 3'd4, 1'b0);
    send({8'h00, ecc_of(24'h123402), 16'h1234}, 3'd3, 1'b1);
    idle(12);
    counts("t5a", 2, 2, 2);
    exp_pld("t5a", 0, {1'b0, 4'hF, 32'h04130201});
    exp_done("t5a", 0, 2'b10);
    // 5b: WC=0 long packet, CRC is the init value
    clr();
    send(hw(8'h1A, 16'h0000), 3'd4, 1'b0);
    send(32'h0000FFFF, 3'd2, 1'b1);
    idle(10);
    counts("t5b", 1, 0, 1);
    exp_hdr("t5b", 0, {8'h1A, 16'h0000, 3'b100});
    exp_done("t5b", 0, 2'b00);

    // 6: burst ends after 6 of 8 payload bytes
    clr();
    send(hw(8'h1A, 16'h0008), 3'd4, 1'b0);
    send(32'h44332211, 3'd4, 1'b0);
    send(32'h00006655, 3'd2, 1'b1);
    idle(10);
    counts("t6", 1, 2, 1);
    exp_pld("t6w0", 0, {1'b0, 4'hF, 32'h44332211});
    exp_pld("t6w1", 1, {1'b1, 4'h3, 32'h00006655});
    exp_done("t6", 0, 2'b01);
    chk("t6_idle_ready", {63'd0, in_ready}, 64'd1);

    // 6b: asynchronous reset in the middle of a payload
    send(hw(8'h1A, 16'h0010), 3'd4, 1'b0);
    send(32'h11111111, 3'd4, 1'b0);
    send(32'h22222222, 3'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 64'({in_ready, hdr_valid, hdr_di, hdr_wc, hdr_long, hdr_ecc_corrected,
        hdr_ecc_fatal, pld_strb, pld_valid, pld_last, pkt_done, crc_err, trunc_err}), 64'd0);
    chk("mid_rst_pld_data", 64'(pld_data), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("mid_rst_idle_ready", {63'd0, in_ready}, 64'd1);
    short_21();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
